regfile_commit_sched: RTL and testbench
=======================================

Name: regfile_commit_sched

Overview:
- Commit-side scheduler for the renaming register file.
- Accepts retiring results from the ROB into a small FIFO and drains them one per cycle into the register file's ROB write port.
- Defers a write when the dispatcher is renaming the same rd in that cycle, which removes the rename/commit tag race.
- Stalls dispatcher reads that hit a buffered, unwritten result, and sequences mispredict recovery (drain, then flush, then hold) so no committed value is lost.

Parameters:
- DEPTH, 4, commit FIFO entries; power of two, ≥2.
- ROB_ID_W, 4, ROB tag width; tag 0 = non-dependent.
- FLUSH_CYCLES, 2, dispatcher stall cycles after mispredict_to_rf.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global ready; low freezes all state.
- commit_valid_from_rob  in  1  ROB presents a retiring result.
- commit_ready_to_rob  out  1  scheduler accepts the result this cycle.
- commit_rd_from_rob  in  5  destination register.
- commit_Q_from_rob  in  ROB_ID_W  tag of the retiring entry.
- commit_V_from_rob  in  32  result value.
- mispredict_from_rob  in  1  branch mispredict pulse.
- rename_valid_from_dsp  in  1  dispatcher renames rd this cycle.
- rename_rd_from_dsp  in  5  register being renamed.
- read_valid_from_dsp  in  1  dispatcher reads rs1/rs2 this cycle.
- rs1_from_dsp, rs2_from_dsp  in  5 each  source registers.
- stall_to_dsp  out  1  dispatcher must not issue this cycle.
- enable_to_rf  out  1  register-file write strobe.
- rd_to_rf  out  5  write destination.
- Q_to_rf  out  ROB_ID_W  write tag.
- V_to_rf  out  32  write data.
- mispredict_to_rf  out  1  clear all register tags.
- count_out  out  log2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst=0, asynchronous): FIFO empty, state RUN, hold counter 0.
  - enable_to_rf, rd_to_rf, Q_to_rf, V_to_rf, mispredict_to_rf all 0.
  - count_out=0, stall_to_dsp=0, commit_ready_to_rob=1.
  - Reset asserted mid-operation discards all buffered entries.
- rdy=0: no state or output register changes; combinational outputs still track state.
- Push rule:
  - commit_ready_to_rob = (state==RUN) && !full. This is conservative: no push when full, even if a pop occurs in the same cycle.
  - A push occurs when valid && ready. Entries with rd=0 complete the handshake but are not stored.
- Pop rule: at each edge with the FIFO non-empty, the head is popped into the rf output registers, unless rename_valid_from_dsp && rename_rd_from_dsp==head.rd.
  - On a pop, enable_to_rf=1 for exactly the following cycle; otherwise enable_to_rf=0.
  - Latency: accepted at edge E, earliest visible at the register file in the cycle after edge E+1.
  - Order is strictly FIFO; a blocked head blocks all younger entries.
- Simultaneous push and pop: both take effect; count is unchanged. Pointers wrap modulo DEPTH.
- stall_to_dsp = (state!=RUN) || (read_valid_from_dsp && any valid FIFO entry has rd!=0 equal to rs1 or rs2).
  - The output register already at the rf port is not checked; the register file bypass covers it.
- State machine:
  - RUN: on mispredict_from_rob go to DRAIN. A push in that same cycle is still accepted, because it is older than the mispredict.
  - DRAIN: no pushes; pops continue. When the FIFO is empty and no write is in flight, go to FLUSH.
  - FLUSH: mispredict_to_rf=1 for one cycle, then go to HOLD with the counter loaded to FLUSH_CYCLES.
  - HOLD: decrement the counter each cycle; go to RUN when it reaches 1 (FLUSH_CYCLES=0 goes straight to RUN).
  - mispredict_from_rob outside RUN is ignored.
- The rename/commit same-rd block still applies during DRAIN. The dispatcher is stalled in DRAIN, so renames only come from that same cycle.

Test Plan:
1. Commit rd=5, Q=3, V=0xDEADBEEF into an empty FIFO -> enable_to_rf=1 for one cycle, two edges later, with rd=5, Q=3, V=0xDEADBEEF; count returns to 0.
2. Hold rename_valid with rename_rd=7; offer 5 back-to-back commits to rd=7 -> 4 accepted, ready drops, count_out=4, no writes; release the rename -> 4 writes on consecutive cycles in order.
3. Blocked entry rd=9 buffered; dispatcher reads rs2=9 -> stall_to_dsp=1. Reads of rs1=rs2=0 or rs=10 -> stall_to_dsp=0.
4. Two entries pending, mispredict pulse -> ready=0, both written, then mispredict_to_rf high for 1 cycle, stall held 1+FLUSH_CYCLES (=3) cycles, then RUN with ready=1.
5. Commit with rd=0 -> handshake completes, count stays 0, enable_to_rf never asserted.
6. Assert rst low mid-DRAIN with 3 entries buffered -> all outputs 0 immediately without a clock edge; after release, state RUN and count_out=0.

Source files
------------

// File: rtl/regfile_commit_sched.sv
// Commit-side scheduler for the renaming register file.
// Retiring ROB results are buffered in a small FIFO and drained one per
// cycle into the register file's ROB write port. A head write is deferred
// while the dispatcher renames the same rd in that cycle. Dispatcher reads
// that hit a buffered result are stalled. Mispredict recovery drains the
// FIFO, flushes all register tags, then holds the dispatcher for a few cycles.

module regfile_commit_sched #(
   parameter int DEPTH        = 4,
   parameter int ROB_ID_W     = 4,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rdy,

   input  logic                      commit_valid_from_rob,
   output logic                      commit_ready_to_rob,
   input  logic [4:0]                commit_rd_from_rob,
   input  logic [ROB_ID_W-1:0]       commit_Q_from_rob,
   input  logic [31:0]               commit_V_from_rob,
   input  logic                      mispredict_from_rob,

   input  logic                      rename_valid_from_dsp,
   input  logic [4:0]                rename_rd_from_dsp,
   input  logic                      read_valid_from_dsp,
   input  logic [4:0]                rs1_from_dsp,
   input  logic [4:0]                rs2_from_dsp,
   output logic                      stall_to_dsp,

   output logic                      enable_to_rf,
   output logic [4:0]                rd_to_rf,
   output logic [ROB_ID_W-1:0]       Q_to_rf,
   output logic [31:0]               V_to_rf,
   output logic                      mispredict_to_rf,

   output logic [$clog2(DEPTH):0]    count_out
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int HOLD_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

   localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
   localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);
   localparam logic [PTR_W-1:0]  PTR_ZERO   = {PTR_W{1'b0}};
   localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(FLUSH_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);
   localparam logic [HOLD_W-1:0] HOLD_ZERO  = {HOLD_W{1'b0}};
   localparam bit                HOLD_USED  = (FLUSH_CYCLES > 0);

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;
   localparam logic [1:0] ST_HOLD  = 2'd3;

   // FIFO storage and bookkeeping
   logic [4:0]           rd_mem_r  [DEPTH];
   logic [ROB_ID_W-1:0]  q_mem_r   [DEPTH];
   logic [31:0]          v_mem_r   [DEPTH];
   logic [DEPTH-1:0]     entry_vld_r;
   logic [PTR_W-1:0]     wr_ptr_r;
   logic [PTR_W-1:0]     rd_ptr_r;
   logic [CNT_W-1:0]     count_r;

   // Recovery sequencer
   logic [1:0]           state_r;
   logic [1:0]           state_nxt_s;
   logic [HOLD_W-1:0]    hold_cnt_r;
   logic [HOLD_W-1:0]    hold_cnt_nxt_s;
   logic                 misp_nxt_s;

   // Register-file write port registers
   logic                 enable_r;
   logic [4:0]           rd_out_r;
   logic [ROB_ID_W-1:0]  q_out_r;
   logic [31:0]          v_out_r;
   logic                 misp_r;

   // Datapath control
   logic                 full_s;
   logic                 empty_s;
   logic                 ready_s;
   logic                 push_s;
   logic                 store_s;
   logic [4:0]           head_rd_s;
   logic                 rename_hit_s;
   logic                 pop_s;
   logic                 read_hit_s;
   logic                 stall_s;

   assign full_s       = (count_r == CNT_FULL);
   assign empty_s      = (count_r == CNT_ZERO);
   assign ready_s      = (state_r == ST_RUN) && !full_s;
   assign push_s       = commit_valid_from_rob && ready_s;
   // rd=0 results finish the handshake but never reach the register file
   assign store_s      = push_s && (commit_rd_from_rob != 5'd0);
   assign head_rd_s    = rd_mem_r[rd_ptr_r];
   assign rename_hit_s = rename_valid_from_dsp && (rename_rd_from_dsp == head_rd_s);
   assign pop_s        = !empty_s && !rename_hit_s;

   // Scan every buffered entry for a source operand that is still in flight
   always_comb begin
      read_hit_s = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         read_hit_s = read_hit_s |
                      (entry_vld_r[i] && (rd_mem_r[i] != 5'd0) &&
                       ((rd_mem_r[i] == rs1_from_dsp) || (rd_mem_r[i] == rs2_from_dsp)));
      end
   end

   // Dispatcher stall: any recovery state, or a read of an unwritten result
   always_comb begin
      if (state_r != ST_RUN) begin
         stall_s = 1'b1;
      end else begin
         stall_s = read_valid_from_dsp && read_hit_s;
      end
   end

   // Recovery sequencer next-state: RUN -> DRAIN -> FLUSH -> HOLD -> RUN
   always_comb begin
      state_nxt_s    = state_r;
      hold_cnt_nxt_s = hold_cnt_r;
      misp_nxt_s     = 1'b0;
      case (state_r)
         ST_RUN: begin
            if (mispredict_from_rob) begin
               state_nxt_s = ST_DRAIN;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_DRAIN: begin
            // wait until nothing is buffered and the last write has landed
            if (empty_s && !enable_r) begin
               state_nxt_s = ST_FLUSH;
               misp_nxt_s  = 1'b1;
            end else begin
               state_nxt_s = ST_DRAIN;
            end
         end
         ST_FLUSH: begin
            if (HOLD_USED) begin
               state_nxt_s    = ST_HOLD;
               hold_cnt_nxt_s = HOLD_LOAD;
            end else begin
               state_nxt_s    = ST_RUN;
               hold_cnt_nxt_s = HOLD_ZERO;
            end
         end
         ST_HOLD: begin
            if (hold_cnt_r <= HOLD_ONE) begin
               state_nxt_s    = ST_RUN;
               hold_cnt_nxt_s = HOLD_ZERO;
            end else begin
               state_nxt_s    = ST_HOLD;
               hold_cnt_nxt_s = hold_cnt_r - HOLD_ONE;
            end
         end
         default: begin
            state_nxt_s    = ST_RUN;
            hold_cnt_nxt_s = HOLD_ZERO;
         end
      endcase
   end

   // FIFO entry storage: write the tail on a stored push, retire the head on a pop
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            rd_mem_r[i] <= 5'd0;
            q_mem_r[i]  <= {ROB_ID_W{1'b0}};
            v_mem_r[i]  <= 32'd0;
         end
         entry_vld_r <= {DEPTH{1'b0}};
      end else if (rdy) begin
         if (store_s) begin
            rd_mem_r[wr_ptr_r]    <= commit_rd_from_rob;
            q_mem_r[wr_ptr_r]     <= commit_Q_from_rob;
            v_mem_r[wr_ptr_r]     <= commit_V_from_rob;
            entry_vld_r[wr_ptr_r] <= 1'b1;
         end
         if (pop_s) begin
            entry_vld_r[rd_ptr_r] <= 1'b0;
         end
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is 2^n
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r <= PTR_ZERO;
         rd_ptr_r <= PTR_ZERO;
         count_r  <= CNT_ZERO;
      end else if (rdy) begin
         if (store_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({store_s, pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // Register-file write port: one-cycle strobe carrying the popped head
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         enable_r <= 1'b0;
         rd_out_r <= 5'd0;
         q_out_r  <= {ROB_ID_W{1'b0}};
         v_out_r  <= 32'd0;
      end else if (rdy) begin
         if (pop_s) begin
            enable_r <= 1'b1;
            rd_out_r <= head_rd_s;
            q_out_r  <= q_mem_r[rd_ptr_r];
            v_out_r  <= v_mem_r[rd_ptr_r];
         end else begin
            enable_r <= 1'b0;
         end
      end
   end

   // Recovery sequencer state, hold counter and the tag-clear pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= ST_RUN;
         hold_cnt_r <= HOLD_ZERO;
         misp_r     <= 1'b0;
      end else if (rdy) begin
         state_r    <= state_nxt_s;
         hold_cnt_r <= hold_cnt_nxt_s;
         misp_r     <= misp_nxt_s;
      end
   end

   assign commit_ready_to_rob = ready_s;
   assign stall_to_dsp        = stall_s;
   assign enable_to_rf        = enable_r;
   assign rd_to_rf            = rd_out_r;
   assign Q_to_rf             = q_out_r;
   assign V_to_rf             = v_out_r;
   assign mispredict_to_rf    = misp_r;
   assign count_out           = count_r;

endmodule

// File: tb/tb_regfile_commit_sched.sv
// Directed self-checking bench for regfile_commit_sched (DEPTH=4, FLUSH_CYCLES=2).
// Inputs change 2 time units after a rising edge; checks happen 1 unit later.

module tb_regfile_commit_sched;

   logic        clk;
   logic        rst;
   logic        rdy;
   logic        commit_valid_from_rob;
   logic        commit_ready_to_rob;
   logic [4:0]  commit_rd_from_rob;
   logic [3:0]  commit_Q_from_rob;
   logic [31:0] commit_V_from_rob;
   logic        mispredict_from_rob;
   logic        rename_valid_from_dsp;
   logic [4:0]  rename_rd_from_dsp;
   logic        read_valid_from_dsp;
   logic [4:0]  rs1_from_dsp;
   logic [4:0]  rs2_from_dsp;
   logic        stall_to_dsp;
   logic        enable_to_rf;
   logic [4:0]  rd_to_rf;
   logic [3:0]  Q_to_rf;
   logic [31:0] V_to_rf;
   logic        mispredict_to_rf;
   logic [2:0]  count_out;

   int tests;
   int fails;

   regfile_commit_sched #(
      .DEPTH(4), .ROB_ID_W(4), .FLUSH_CYCLES(2)
   ) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .commit_valid_from_rob(commit_valid_from_rob),
      .commit_ready_to_rob(commit_ready_to_rob),
      .commit_rd_from_rob(commit_rd_from_rob),
      .commit_Q_from_rob(commit_Q_from_rob),
      .commit_V_from_rob(commit_V_from_rob),
      .mispredict_from_rob(mispredict_from_rob),
      .rename_valid_from_dsp(rename_valid_from_dsp),
      .rename_rd_from_dsp(rename_rd_from_dsp),
      .read_valid_from_dsp(read_valid_from_dsp),
      .rs1_from_dsp(rs1_from_dsp),
      .rs2_from_dsp(rs2_from_dsp),
      .stall_to_dsp(stall_to_dsp),
      .enable_to_rf(enable_to_rf),
      .rd_to_rf(rd_to_rf),
      .Q_to_rf(Q_to_rf),
      .V_to_rf(V_to_rf),
      .mispredict_to_rf(mispredict_to_rf),
      .count_out(count_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic commit(input logic v, input logic [4:0] rd, input logic [3:0] q, input logic [31:0] val);
      commit_valid_from_rob = v;
      commit_rd_from_rob    = rd;
      commit_Q_from_rob     = q;
      commit_V_from_rob     = val;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst = 1'b0;
      rdy = 1'b1;
      commit(1'b0, 5'd0, 4'd0, 32'd0);
      mispredict_from_rob   = 1'b0;
      rename_valid_from_dsp = 1'b0;
      rename_rd_from_dsp    = 5'd0;
      read_valid_from_dsp   = 1'b0;
      rs1_from_dsp          = 5'd0;
      rs2_from_dsp          = 5'd0;

      // ---- reset state ----
      #12;
      chk("rst_en",    enable_to_rf, 32'd0);
      chk("rst_rd",    rd_to_rf, 32'd0);
      chk("rst_q",     Q_to_rf, 32'd0);
      chk("rst_v",     V_to_rf, 32'd0);
      chk("rst_misp",  mispredict_to_rf, 32'd0);
      chk("rst_count", count_out, 32'd0);
      chk("rst_stall", stall_to_dsp, 32'd0);
      chk("rst_ready", commit_ready_to_rob, 32'd1);
      rst = 1'b1;
      tick();

      // ---- 1: single commit, written two edges after acceptance ----
      commit(1'b1, 5'd5, 4'd3, 32'hDEADBEEF);
      #1;
      chk("t1_ready", commit_ready_to_rob, 32'd1);
      tick();
      commit(1'b0, 5'd0, 4'd0, 32'd0);
      #1;
      chk("t1_count1", count_out, 32'd1);
      chk("t1_en_e1",  enable_to_rf, 32'd0);
      tick();
      chk("t1_en",     enable_to_rf, 32'd1);
      chk("t1_rd",     rd_to_rf, 32'd5);
      chk("t1_q",      Q_to_rf, 32'd3);
      chk("t1_v",      V_to_rf, 32'hDEADBEEF);
      chk("t1_count0", count_out, 32'd0);
      tick();
      chk("t1_en_off", enable_to_rf, 32'd0);

      // ---- 2: rename block on rd=7, FIFO fills, then drains in order ----
      rename_valid_from_dsp = 1'b1;
      rename_rd_from_dsp    = 5'd7;
      for (int i = 0; i < 5; i++) begin
         commit(1'b1, 5'd7, 4'(i + 1), 32'h100 + 32'(i));
         #1;
         chk("t2_ready", commit_ready_to_rob, (i < 4) ? 32'd1 : 32'd0);
         chk("t2_noen",  enable_to_rf, 32'd0);
         tick();
      end
      commit(1'b0, 5'd0, 4'd0, 32'd0);
      #1;
      chk("t2_count4", count_out, 32'd4);
      chk("t2_noen2",  enable_to_rf, 32'd0);
      rename_valid_from_dsp = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t2_en", enable_to_rf, 32'd1);
         chk("t2_rd", rd_to_rf, 32'd7);
         chk("t2_q",  Q_to_rf, 32'(i + 1));
         chk("t2_v",  V_to_rf, 32'h100 + 32'(i));
      end
      tick();
      chk("t2_en_off", enable_to_rf, 32'd0);
      chk("t2_count0", count_out, 32'd0);

      // ---- 3: read stall against a buffered rd=9 ----
      rename_valid_from_dsp = 1'b1;
      rename_rd_from_dsp    = 5'd9;
      commit(1'b1, 5'd9, 4'd2, 32'h99);
      tick();
      commit(1'b0, 5'd0, 4'd0, 32'd0);
      read_valid_from_dsp = 1'b1;
      rs1_from_dsp = 5'd3;
      rs2_from_dsp = 5'd9;
      #1;
      chk("t3_count",    count_out, 32'd1);
      chk("t3_stall_rs2", stall_to_dsp, 32'd1);
      rs1_from_dsp = 5'd0;
      rs2_from_dsp = 5'd0;
      #1;
      chk("t3_stall_r0", stall_to_dsp, 32'd0);
      rs1_from_dsp = 5'd10;
      rs2_from_dsp = 5'd10;
      #1;
      chk("t3_stall_r10", stall_to_dsp, 32'd0);
      rs1_from_dsp = 5'd9;
      rs2_from_dsp = 5'd0;
      #1;
      chk("t3_stall_rs1", stall_to_dsp, 32'd1);
      read_valid_from_dsp = 1'b0;
      #1;
      chk("t3_stall_nord", stall_to_dsp, 32'd0);

      // ---- 4: mispredict recovery with two entries pending ----
      commit(1'b1, 5'd11, 4'd4, 32'hB0B);
      tick();
      commit(1'b0, 5'd0, 4'd0, 32'd0);
      #1;
      chk("t4_count2", count_out, 32'd2);
      rename_valid_from_dsp = 1'b0;
      mispredict_from_rob   = 1'b1;
      tick();
      mispredict_from_rob = 1'b0;
      #1;
      chk("t4_c1_ready", commit_ready_to_rob, 32'd0);
      chk("t4_c1_stall", stall_to_dsp, 32'd1);
      chk("t4_c1_en",    enable_to_rf, 32'd1);
      chk("t4_c1_rd",    rd_to_rf, 32'd9);
      chk("t4_c1_v",     V_to_rf, 32'h99);
      chk("t4_c1_count", count_out, 32'd1);
      tick();
      chk("t4_c2_en",    enable_to_rf, 32'd1);
      chk("t4_c2_rd",    rd_to_rf, 32'd11);
      chk("t4_c2_q",     Q_to_rf, 32'd4);
      chk("t4_c2_v",     V_to_rf, 32'hB0B);
      chk("t4_c2_count", count_out, 32'd0);
      chk("t4_c2_misp",  mispredict_to_rf, 32'd0);
      tick();
      chk("t4_c3_en",    enable_to_rf, 32'd0);
      chk("t4_c3_misp",  mispredict_to_rf, 32'd0);
      chk("t4_c3_stall", stall_to_dsp, 32'd1);
      tick();
      mispredict_from_rob = 1'b1;
      #1;
      chk("t4_flush_misp",  mispredict_to_rf, 32'd1);
      chk("t4_flush_stall", stall_to_dsp, 32'd1);
      chk("t4_flush_ready", commit_ready_to_rob, 32'd0);
      tick();
      mispredict_from_rob = 1'b0;
      chk("t4_hold1_misp",  mispredict_to_rf, 32'd0);
      chk("t4_hold1_stall", stall_to_dsp, 32'd1);
      tick();
      chk("t4_hold2_stall", stall_to_dsp, 32'd1);
      chk("t4_hold2_ready", commit_ready_to_rob, 32'd0);
      tick();
      chk("t4_run_stall", stall_to_dsp, 32'd0);
      chk("t4_run_ready", commit_ready_to_rob, 32'd1);
      chk("t4_run_misp",  mispredict_to_rf, 32'd0);

      // ---- 5: rd=0 commit completes handshake but is not stored ----
      commit(1'b1, 5'd0, 4'd1, 32'h5);
      #1;
      chk("t5_ready", commit_ready_to_rob, 32'd1);
      tick();
      commit(1'b0, 5'd0, 4'd0, 32'd0);
      #1;
      chk("t5_count", count_out, 32'd0);
      chk("t5_en0",   enable_to_rf, 32'd0);
      tick();
      chk("t5_en1",   enable_to_rf, 32'd0);

      // ---- 6: async reset mid-DRAIN with 3 entries buffered ----
      rename_valid_from_dsp = 1'b1;
      rename_rd_from_dsp    = 5'd12;
      for (int i = 0; i < 4; i++) begin
         commit(1'b1, 5'd12, 4'(i + 1), 32'h600 + 32'(i));
         mispredict_from_rob = (i == 3);
         #1;
         chk("t6_ready", commit_ready_to_rob, 32'd1);
         tick();
      end
      commit(1'b0, 5'd0, 4'd0, 32'd0);
      mispredict_from_rob = 1'b0;
      #1;
      chk("t6_count4",    count_out, 32'd4);
      chk("t6_drain_rdy", commit_ready_to_rob, 32'd0);
      chk("t6_drain_stl", stall_to_dsp, 32'd1);
      rename_valid_from_dsp = 1'b0;
      tick();
      rename_valid_from_dsp = 1'b1;
      #1;
      chk("t6_count3", count_out, 32'd3);
      chk("t6_en",     enable_to_rf, 32'd1);
      chk("t6_q",      Q_to_rf, 32'd1);
      read_valid_from_dsp = 1'b1;
      rs1_from_dsp = 5'd12;
      rs2_from_dsp = 5'd12;
      rst = 1'b0;
      #1;
      chk("t6_rst_en",    enable_to_rf, 32'd0);
      chk("t6_rst_rd",    rd_to_rf, 32'd0);
      chk("t6_rst_q",     Q_to_rf, 32'd0);
      chk("t6_rst_v",     V_to_rf, 32'd0);
      chk("t6_rst_misp",  mispredict_to_rf, 32'd0);
      chk("t6_rst_count", count_out, 32'd0);
      chk("t6_rst_stall", stall_to_dsp, 32'd0);
      chk("t6_rst_ready", commit_ready_to_rob, 32'd1);
      #2;
      rst = 1'b1;
      tick();
      chk("t6_post_count", count_out, 32'd0);
      chk("t6_post_stall", stall_to_dsp, 32'd0);
      chk("t6_post_ready", commit_ready_to_rob, 32'd1);
      chk("t6_post_en",    enable_to_rf, 32'd0);
      read_valid_from_dsp   = 1'b0;
      rename_valid_from_dsp = 1'b0;
      commit(1'b1, 5'd3, 4'd5, 32'h33);
      tick();
      commit(1'b0, 5'd0, 4'd0, 32'd0);
      tick();
      chk("t6_new_en", enable_to_rf, 32'd1);
      chk("t6_new_rd", rd_to_rf, 32'd3);
      chk("t6_new_v",  V_to_rf, 32'h33);

      // ---- 7: rdy=0 freezes state and output registers ----
      tick();
      commit(1'b1, 5'd4, 4'd6, 32'h44);
      tick();
      commit(1'b0, 5'd0, 4'd0, 32'd0);
      rdy = 1'b0;
      tick();
      chk("t7_frz_count", count_out, 32'd1);
      chk("t7_frz_en",    enable_to_rf, 32'd0);
      chk("t7_frz_v",     V_to_rf, 32'h33);
      rdy = 1'b1;
      tick();
      chk("t7_en",    enable_to_rf, 32'd1);
      chk("t7_v",     V_to_rf, 32'h44);
      chk("t7_count", count_out, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
